// File: rtl/pc_ctrl_fsm.sv
// Multicycle fetch/decode/execute controller driving the PC-select field,
// PC/IR write enables, memory strobes with a ready handshake and a retire counter.
module pc_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  output logic [2:0]       ctrl_pc,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,  S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC = 4'd3,
    S_WB     = 4'd4,  S_ADDR  = 4'd5, S_MEM    = 4'd6, S_BRANCH = 4'd7,
    S_JUMP   = 4'd8,  S_JAL   = 4'd9, S_JR     = 4'd10, S_SYS   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_SYS   = 6'h0C;

  state_t     state_q, state_nx;
  logic [5:0] op_q;
  logic       ret_inc;
  logic       ill_set;

  function automatic logic is_illegal(input logic [5:0] op);
    return !(op == OP_RTYPE || op == OP_J || op == OP_JAL || op == OP_BEQ ||
             op == OP_BNE || op[5:3] == 3'b001 || op == OP_LW || op == OP_SW);
  endfunction

  function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] fn);
    state_t s;
    s = S_SYS;
    if (op == OP_RTYPE) begin
      if (fn == FN_JR)       s = S_JR;
      else if (fn == FN_SYS) s = S_SYS;
      else                   s = S_EXEC;
    end
    else if (op == OP_J)                   s = S_JUMP;
    else if (op == OP_JAL)                 s = S_JAL;
    else if (op == OP_BEQ || op == OP_BNE) s = S_BRANCH;
    else if (op[5:3] == 3'b001)            s = S_EXEC;
    else if (op == OP_LW || op == OP_SW)   s = S_ADDR;
    return s;
  endfunction

  assign state = state_q;

  // Outputs are a decode of the current state; only FETCH/MEM look at mem_ready.
  always_comb begin
    state_nx  = state_q;
    ret_inc   = 1'b0;
    ill_set   = 1'b0;
    ctrl_pc   = 3'b000;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        ctrl_pc  = 3'b011;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        state_nx = dispatch(opcode, funct);
        ill_set  = is_illegal(opcode);
      end
      S_EXEC: state_nx = S_WB;
      S_WB: begin
        reg_write = 1'b1;
        state_nx  = S_FETCH;
        ret_inc   = 1'b1;
      end
      S_ADDR: state_nx = S_MEM;
      S_MEM: begin
        mem_read  = (op_q == OP_LW);
        mem_write = (op_q == OP_SW);
        if (mem_ready) begin
          if (op_q == OP_LW) begin
            state_nx = S_WB;
          end else begin
            state_nx = S_FETCH;
            ret_inc  = 1'b1;
          end
        end
      end
      S_BRANCH: begin
        ctrl_pc  = 3'b010;
        pc_write = ((op_q == OP_BEQ) && alu_zero) || ((op_q == OP_BNE) && !alu_zero);
        state_nx = S_FETCH;
        ret_inc  = 1'b1;
      end
      S_JUMP, S_JAL: begin
        pc_write  = 1'b1;
        reg_write = (state_q == S_JAL);
        state_nx  = S_FETCH;
        ret_inc   = 1'b1;
      end
      S_JR: begin
        ctrl_pc  = 3'b001;
        pc_write = 1'b1;
        state_nx = S_FETCH;
        ret_inc  = 1'b1;
      end
      S_SYS: begin
        ctrl_pc  = 3'b100;
        pc_write = 1'b1;
        state_nx = S_FETCH;
        ret_inc  = 1'b1;
      end
      default: state_nx = S_FETCH;  // IDLE and the unused encodings
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= 6'd0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state_q <= state_nx;
      if (state_q == S_DECODE) op_q <= opcode;
      if (ill_set)             illegal <= 1'b1;
      if (ret_inc)             retired <= retired + 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_ctrl_fsm.sv
// Directed bench for pc_ctrl_fsm: a per-cycle vector table for the instruction
// mix, then hand sequences for reset during MEM and retire-counter wrap.
module tb_pc_ctrl_fsm;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_ready;
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic          alu_zero;
  logic [2:0]    ctrl_pc;
  logic          pc_write, ir_write, mem_read, mem_write, reg_write, illegal;
  logic [3:0]    state;
  logic [CW-1:0] retired;

  pc_ctrl_fsm #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .mem_ready(mem_ready), .opcode(opcode),
    .funct(funct), .alu_zero(alu_zero), .ctrl_pc(ctrl_pc), .pc_write(pc_write),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .illegal(illegal), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mr;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic [16:0] exp;  // {state, ctrl_pc, pw, iw, mrd, mwr, rw, ill, retired}
  } vec_t;

  vec_t vq[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [16:0] pk(input logic [3:0] st, input logic [2:0] cpc,
                                     input logic pw, input logic iw, input logic mrd,
                                     input logic mwr, input logic rw, input logic ill,
                                     input logic [3:0] ret);
    return {st, cpc, pw, iw, mrd, mwr, rw, ill, ret};
  endfunction

  function automatic logic [16:0] act();
    return {state, ctrl_pc, pc_write, ir_write, mem_read, mem_write, reg_write,
            illegal, retired};
  endfunction

  task automatic v(input logic mr, input logic [5:0] op, input logic [5:0] fn,
                   input logic z, input logic [3:0] st, input logic [2:0] cpc,
                   input logic pw, input logic iw, input logic mrd, input logic mwr,
                   input logic rw, input logic ill, input logic [3:0] ret);
    vec_t r;
    r.mr = mr; r.op = op; r.fn = fn; r.z = z;
    r.exp = pk(st, cpc, pw, iw, mrd, mwr, rw, ill, ret);
    vq.push_back(r);
  endtask

  task automatic chk(input string name, input logic [16:0] a, input logic [16:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got st=%0d cpc=%b pw/iw/mr/mw/rw/ill=%b ret=%0d, need st=%0d cpc=%b pw/iw/mr/mw/rw/ill=%b ret=%0d",
               name, a[16:13], a[12:10], a[9:4], a[3:0], e[16:13], e[12:10], e[9:4], e[3:0]);
    end
  endtask

  task automatic chk_val(input string name, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0d, need %0d", name, a, e);
    end
  endtask

  initial begin
    //  mr  op     fn     z   st  cpc     pw iw mr mw rw il ret
    v(1, 6'h00, 6'h20, 0, 0,  3'b000, 0, 0, 0, 0, 0, 0, 0);   // IDLE
    v(1, 6'h00, 6'h20, 0, 1,  3'b011, 1, 1, 1, 0, 0, 0, 0);   // add
    v(1, 6'h00, 6'h20, 0, 2,  3'b000, 0, 0, 0, 0, 0, 0, 0);
    v(1, 6'h00, 6'h20, 0, 3,  3'b000, 0, 0, 0, 0, 0, 0, 0);
    v(1, 6'h00, 6'h20, 0, 4,  3'b000, 0, 0, 0, 0, 1, 0, 0);
    v(1, 6'h04, 6'h00, 1, 1,  3'b011, 1, 1, 1, 0, 0, 0, 1);   // beq taken
    v(1, 6'h04, 6'h00, 1, 2,  3'b000, 0, 0, 0, 0, 0, 0, 1);
    v(1, 6'h04, 6'h00, 1, 7,  3'b010, 1, 0, 0, 0, 0, 0, 1);
    v(1, 6'h04, 6'h00, 0, 1,  3'b011, 1, 1, 1, 0, 0, 0, 2);   // beq not taken
    v(1, 6'h04, 6'h00, 0, 2,  3'b000, 0, 0, 0, 0, 0, 0, 2);
    v(1, 6'h04, 6'h00, 0, 7,  3'b010, 0, 0, 0, 0, 0, 0, 2);
    v(1, 6'h23, 6'h00, 0, 1,  3'b011, 1, 1, 1, 0, 0, 0, 3);   // lw, two MEM stalls
    v(1, 6'h23, 6'h00, 0, 2,  3'b000, 0, 0, 0, 0, 0, 0, 3);
    v(1, 6'h23, 6'h00, 0, 5,  3'b000, 0, 0, 0, 0, 0, 0, 3);
    v(0, 6'h23, 6'h00, 0, 6,  3'b000, 0, 0, 1, 0, 0, 0, 3);
    v(0, 6'h23, 6'h00, 0, 6,  3'b000, 0, 0, 1, 0, 0, 0, 3);
    v(1, 6'h23, 6'h00, 0, 6,  3'b000, 0, 0, 1, 0, 0, 0, 3);
    v(1, 6'h23, 6'h00, 0, 4,  3'b000, 0, 0, 0, 0, 1, 0, 3);
    v(0, 6'h3F, 6'h00, 0, 1,  3'b011, 0, 0, 1, 0, 0, 0, 4);   // fetch stall
    v(1, 6'h3F, 6'h00, 0, 1,  3'b011, 1, 1, 1, 0, 0, 0, 4);   // illegal op
    v(1, 6'h3F, 6'h00, 0, 2,  3'b000, 0, 0, 0, 0, 0, 0, 4);
    v(1, 6'h3F, 6'h00, 0, 11, 3'b100, 1, 0, 0, 0, 0, 1, 4);
    v(1, 6'h00, 6'h08, 0, 1,  3'b011, 1, 1, 1, 0, 0, 1, 5);   // jr
    v(1, 6'h00, 6'h08, 0, 2,  3'b000, 0, 0, 0, 0, 0, 1, 5);
    v(1, 6'h00, 6'h08, 0, 10, 3'b001, 1, 0, 0, 0, 0, 1, 5);
    v(1, 6'h03, 6'h00, 0, 1,  3'b011, 1, 1, 1, 0, 0, 1, 6);   // jal
    v(1, 6'h03, 6'h00, 0, 2,  3'b000, 0, 0, 0, 0, 0, 1, 6);
    v(1, 6'h03, 6'h00, 0, 9,  3'b000, 1, 0, 0, 0, 1, 1, 6);
    v(1, 6'h02, 6'h00, 0, 1,  3'b011, 1, 1, 1, 0, 0, 1, 7);   // j
    v(1, 6'h02, 6'h00, 0, 2,  3'b000, 0, 0, 0, 0, 0, 1, 7);
    v(1, 6'h02, 6'h00, 0, 8,  3'b000, 1, 0, 0, 0, 0, 1, 7);
    v(1, 6'h00, 6'h0C, 0, 1,  3'b011, 1, 1, 1, 0, 0, 1, 8);   // syscall
    v(1, 6'h00, 6'h0C, 0, 2,  3'b000, 0, 0, 0, 0, 0, 1, 8);
    v(1, 6'h00, 6'h0C, 0, 11, 3'b100, 1, 0, 0, 0, 0, 1, 8);
    v(1, 6'h08, 6'h00, 0, 1,  3'b011, 1, 1, 1, 0, 0, 1, 9);   // addi
    v(1, 6'h08, 6'h00, 0, 2,  3'b000, 0, 0, 0, 0, 0, 1, 9);
    v(1, 6'h08, 6'h00, 0, 3,  3'b000, 0, 0, 0, 0, 0, 1, 9);
    v(1, 6'h08, 6'h00, 0, 4,  3'b000, 0, 0, 0, 0, 1, 1, 9);
    v(1, 6'h05, 6'h00, 0, 1,  3'b011, 1, 1, 1, 0, 0, 1, 10);  // bne taken
    v(1, 6'h05, 6'h00, 0, 2,  3'b000, 0, 0, 0, 0, 0, 1, 10);
    v(1, 6'h05, 6'h00, 0, 7,  3'b010, 1, 0, 0, 0, 0, 1, 10);
    v(1, 6'h2B, 6'h00, 0, 1,  3'b011, 1, 1, 1, 0, 0, 1, 11);  // sw
    v(1, 6'h2B, 6'h00, 0, 2,  3'b000, 0, 0, 0, 0, 0, 1, 11);
    v(1, 6'h2B, 6'h00, 0, 5,  3'b000, 0, 0, 0, 0, 0, 1, 11);
    v(1, 6'h2B, 6'h00, 0, 6,  3'b000, 0, 0, 0, 1, 0, 1, 11);
    v(1, 6'h2B, 6'h00, 0, 1,  3'b011, 1, 1, 1, 0, 0, 1, 12);  // sw, stalled in MEM
    v(1, 6'h2B, 6'h00, 0, 2,  3'b000, 0, 0, 0, 0, 0, 1, 12);
    v(1, 6'h2B, 6'h00, 0, 5,  3'b000, 0, 0, 0, 0, 0, 1, 12);
    v(0, 6'h2B, 6'h00, 0, 6,  3'b000, 0, 0, 0, 1, 0, 1, 12);

    reset = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0; alu_zero = 1'b0;
    @(negedge clk);
    chk("reset_state", act(), pk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    reset = 1'b1;

    foreach (vq[i]) begin
      mem_ready = vq[i].mr; opcode = vq[i].op; funct = vq[i].fn; alu_zero = vq[i].z;
      @(negedge clk);
      chk($sformatf("vec%0d", i), act(), vq[i].exp);
      @(posedge clk); #1;
    end

    // Still in MEM with the store pending; reset must clear everything at once.
    chk("sw_mem_held", act(), pk(6, 3'b000, 0, 0, 0, 1, 0, 1, 12));
    reset = 1'b0;
    #1;
    chk("reset_mid_mem", act(), pk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    chk("reset_held", act(), pk(0, 3'b000, 0, 0, 0, 0, 0, 0, 0));

    // Retire fifteen jumps, then one more to wrap the counter.
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'h02; funct = '0;
    @(posedge clk); #1;
    chk_val("first_fetch", int'(state), 1);
    for (int k = 0; k < 45; k++) begin
      @(posedge clk); #1;
    end
    chk_val("retired_max", int'(retired), 15);
    chk_val("state_at_max", int'(state), 1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk_val("retired_wrap", int'(retired), 0);
    chk_val("state_at_wrap", int'(state), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: sim time exceeded limit, required finish");
    $fatal(1, "timeout");
  end

endmodule
